// File: rtl/enemy_hittracker_if.sv
// Pixel-rate bus between the enemy pipeline and the hit tracker.
// The master side drives the per-pixel requests; the slave side returns the tracker state.
interface enemy_hittracker_if #(
  parameter int AMOUNT_OF_ENEMIES = 2
) ();
  logic                         start_of_frame;
  logic                         pause;
  logic                         enemy_draw_req;
  logic [3:0]                   drawing_requestor_id;
  logic [2:0]                   shot_draw_req;
  logic [AMOUNT_OF_ENEMIES-1:0] alive_mask;
  logic [15:0]                  score;
  logic [7:0]                   wave_count;
  logic [2:0]                   shot_hit;
  logic                         kill_pulse;
  logic                         wave_clear;

  modport master (
    output start_of_frame, pause, enemy_draw_req, drawing_requestor_id, shot_draw_req,
    input  alive_mask, score, wave_count, shot_hit, kill_pulse, wave_clear
  );

  modport slave (
    input  start_of_frame, pause, enemy_draw_req, drawing_requestor_id, shot_draw_req,
    output alive_mask, score, wave_count, shot_hit, kill_pulse, wave_clear
  );
endinterface

// File: rtl/enemy_hittracker.sv
// Accumulates per-pixel enemy/shot overlaps over a frame and commits them at frame start
// into hit points, an alive mask, a saturating score and a wave counter.
module enemy_hittracker #(
  parameter int AMOUNT_OF_ENEMIES = 2,
  parameter int HIT_POINTS        = 2,
  parameter int POINTS_PER_KILL   = 10,
  parameter int WAVE_DELAY_FRAMES = 60
) (
  input  logic              clk,
  input  logic              reset,
  enemy_hittracker_if.slave bus
);
  localparam int          N          = AMOUNT_OF_ENEMIES;
  localparam logic [2:0]  HP_INIT    = 3'(HIT_POINTS);
  localparam logic [7:0]  LAST_FRAME = 8'(WAVE_DELAY_FRAMES - 1);
  localparam logic [16:0] PTS        = 17'(POINTS_PER_KILL);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    COMMIT     = 2'd1,
    WAVE_CLEAR = 2'd2,
    RELOAD     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  alive_q, alive_d;
  logic [N-1:0]  hit_pend_q, hit_pend_d;
  logic [2:0]    hp_q [N];
  logic [2:0]    hp_d [N];
  logic [2:0]    shot_pend_q, shot_pend_d;
  logic [15:0]   score_q, score_d;
  logic [7:0]    wave_q, wave_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [2:0]    shot_hit_q, shot_hit_d;
  logic          kill_pulse_q, kill_pulse_d;
  logic          wave_clear_q, wave_clear_d;

  logic          qual_en;
  logic [N-1:0]  enemy_hit;
  logic [N-1:0]  qual_enemy;
  logic [2:0]    qual_shot;
  logic [N-1:0]  kill_vec;
  logic [4:0]    kill_cnt;
  logic [16:0]   score_sum;

  // Qualified hits: ids outside 0..N-1 never match any enemy_hit bit.
  always_comb begin
    qual_en = !bus.pause && (state_q != WAVE_CLEAR);
    for (int i = 0; i < N; i++) begin
      enemy_hit[i] = bus.enemy_draw_req && (bus.drawing_requestor_id == 4'(i)) && alive_q[i];
    end
    qual_enemy = ((|bus.shot_draw_req) && qual_en) ? enemy_hit : {N{1'b0}};
    qual_shot  = ((|enemy_hit) && qual_en) ? bus.shot_draw_req : 3'b000;
  end

  // Kills and the clamped score for the pending hits of the closing frame.
  always_comb begin
    kill_cnt = 5'd0;
    for (int i = 0; i < N; i++) begin
      kill_vec[i] = hit_pend_q[i] && alive_q[i] && (hp_q[i] == 3'd1);
      kill_cnt    = kill_cnt + {4'd0, kill_vec[i]};
    end
    score_sum = {1'b0, score_q} + (17'(kill_cnt) * PTS);
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d      = state_q;
    alive_d      = alive_q;
    hit_pend_d   = hit_pend_q;
    shot_pend_d  = shot_pend_q;
    hp_d         = hp_q;
    score_d      = score_q;
    wave_d       = wave_q;
    frame_cnt_d  = frame_cnt_q;
    shot_hit_d   = 3'b000;
    kill_pulse_d = 1'b0;
    case (state_q)
      RUN: begin
        hit_pend_d  = hit_pend_q | qual_enemy;
        shot_pend_d = shot_pend_q | qual_shot;
        if (bus.start_of_frame && !bus.pause) begin
          state_d = COMMIT;
        end else begin
          state_d = RUN;
        end
      end
      COMMIT: begin
        for (int i = 0; i < N; i++) begin
          if (hit_pend_q[i] && alive_q[i] && (hp_q[i] != 3'd0)) begin
            hp_d[i] = hp_q[i] - 3'd1;
          end else begin
            hp_d[i] = hp_q[i];
          end
        end
        alive_d      = alive_q & ~kill_vec;
        score_d      = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        shot_hit_d   = shot_pend_q;
        kill_pulse_d = (kill_cnt != 5'd0);
        // Hits seen during the commit cycle open the next frame's accumulation.
        hit_pend_d   = qual_enemy;
        shot_pend_d  = qual_shot;
        if (alive_d == {N{1'b0}}) begin
          state_d     = WAVE_CLEAR;
          frame_cnt_d = 8'd0;
        end else begin
          state_d = RUN;
        end
      end
      WAVE_CLEAR: begin
        if (bus.start_of_frame && !bus.pause) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (frame_cnt_q == LAST_FRAME) begin
            state_d = RELOAD;
          end else begin
            state_d = WAVE_CLEAR;
          end
        end else begin
          state_d = WAVE_CLEAR;
        end
      end
      RELOAD: begin
        alive_d     = {N{1'b1}};
        for (int i = 0; i < N; i++) begin
          hp_d[i] = HP_INIT;
        end
        wave_d      = wave_q + 8'd1;
        hit_pend_d  = {N{1'b0}};
        shot_pend_d = 3'b000;
        state_d     = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    wave_clear_d = (state_d == WAVE_CLEAR);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      alive_q      <= {N{1'b1}};
      hit_pend_q   <= {N{1'b0}};
      shot_pend_q  <= 3'b000;
      for (int i = 0; i < N; i++) begin
        hp_q[i] <= HP_INIT;
      end
      score_q      <= 16'd0;
      wave_q       <= 8'd0;
      frame_cnt_q  <= 8'd0;
      shot_hit_q   <= 3'b000;
      kill_pulse_q <= 1'b0;
      wave_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      alive_q      <= alive_d;
      hit_pend_q   <= hit_pend_d;
      shot_pend_q  <= shot_pend_d;
      hp_q         <= hp_d;
      score_q      <= score_d;
      wave_q       <= wave_d;
      frame_cnt_q  <= frame_cnt_d;
      shot_hit_q   <= shot_hit_d;
      kill_pulse_q <= kill_pulse_d;
      wave_clear_q <= wave_clear_d;
    end
  end

  assign bus.alive_mask = alive_q;
  assign bus.score      = score_q;
  assign bus.wave_count = wave_q;
  assign bus.shot_hit   = shot_hit_q;
  assign bus.kill_pulse = kill_pulse_q;
  assign bus.wave_clear = wave_clear_q;
endmodule

// File: tb/tb_enemy_hittracker.sv
// Directed bench for enemy_hittracker: a default instance plus a 1-hp, high-score instance
// used to reach score saturation within a few waves.
module tb_enemy_hittracker;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  enemy_hittracker_if #(.AMOUNT_OF_ENEMIES(2)) bus ();
  enemy_hittracker_if #(.AMOUNT_OF_ENEMIES(2)) bus2 ();

  enemy_hittracker #(
    .AMOUNT_OF_ENEMIES(2), .HIT_POINTS(2), .POINTS_PER_KILL(10), .WAVE_DELAY_FRAMES(60)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  enemy_hittracker #(
    .AMOUNT_OF_ENEMIES(2), .HIT_POINTS(1), .POINTS_PER_KILL(8191), .WAVE_DELAY_FRAMES(1)
  ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.start_of_frame = 1'b0;  bus.pause = 1'b0;  bus.enemy_draw_req = 1'b0;
    bus.drawing_requestor_id = 4'd0;  bus.shot_draw_req = 3'b000;
    bus2.start_of_frame = 1'b0; bus2.pause = 1'b0; bus2.enemy_draw_req = 1'b0;
    bus2.drawing_requestor_id = 4'd0; bus2.shot_draw_req = 3'b000;
  endtask

  task automatic pixels(input logic [3:0] id, input logic [2:0] shots, input int n);
    bus.enemy_draw_req = 1'b1; bus.drawing_requestor_id = id; bus.shot_draw_req = shots;
    repeat (n) tick();
    bus.enemy_draw_req = 1'b0; bus.drawing_requestor_id = 4'd0; bus.shot_draw_req = 3'b000;
  endtask

  // Frame strobe; returns one cycle after the strobe edge, when committed outputs are visible.
  task automatic frame(input logic paused);
    bus.pause = paused; bus.start_of_frame = 1'b1;
    tick();
    bus.start_of_frame = 1'b0;
    tick();
    bus.pause = 1'b0;
  endtask

  task automatic pixels2(input logic [3:0] id, input logic [2:0] shots);
    bus2.enemy_draw_req = 1'b1; bus2.drawing_requestor_id = id; bus2.shot_draw_req = shots;
    tick();
    bus2.enemy_draw_req = 1'b0; bus2.drawing_requestor_id = 4'd0; bus2.shot_draw_req = 3'b000;
  endtask

  task automatic frame2();
    bus2.start_of_frame = 1'b1;
    tick();
    bus2.start_of_frame = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.alive_mask !== 2'b11) begin errors++; $display("FAIL reset_alive got %b exp 11", bus.alive_mask); end
    checks++; if (bus.score !== 16'd0) begin errors++; $display("FAIL reset_score got %0d exp 0", bus.score); end
    checks++; if (bus.wave_count !== 8'd0) begin errors++; $display("FAIL reset_wave got %0d exp 0", bus.wave_count); end
    checks++; if (bus.shot_hit !== 3'b000) begin errors++; $display("FAIL reset_shot_hit got %b exp 000", bus.shot_hit); end
    checks++; if (bus.kill_pulse !== 1'b0) begin errors++; $display("FAIL reset_kill got %b exp 0", bus.kill_pulse); end
    checks++; if (bus.wave_clear !== 1'b0) begin errors++; $display("FAIL reset_wave_clear got %b exp 0", bus.wave_clear); end
  endtask

  task automatic test_single_hit();
    pixels(4'd0, 3'b001, 5);
    frame(1'b0);
    checks++; if (bus.shot_hit !== 3'b001) begin errors++; $display("FAIL hit1_shot_hit got %b exp 001", bus.shot_hit); end
    checks++; if (dut.hp_q[0] !== 3'd1) begin errors++; $display("FAIL hit1_hp0 got %0d exp 1", dut.hp_q[0]); end
    checks++; if (bus.alive_mask !== 2'b11) begin errors++; $display("FAIL hit1_alive got %b exp 11", bus.alive_mask); end
    checks++; if (bus.score !== 16'd0) begin errors++; $display("FAIL hit1_score got %0d exp 0", bus.score); end
    checks++; if (bus.kill_pulse !== 1'b0) begin errors++; $display("FAIL hit1_kill got %b exp 0", bus.kill_pulse); end
    tick();
    checks++; if (bus.shot_hit !== 3'b000) begin errors++; $display("FAIL hit1_pulse_len got %b exp 000", bus.shot_hit); end
  endtask

  task automatic test_kill();
    pixels(4'd0, 3'b001, 5);
    frame(1'b0);
    checks++; if (bus.alive_mask !== 2'b10) begin errors++; $display("FAIL kill_alive got %b exp 10", bus.alive_mask); end
    checks++; if (bus.score !== 16'd10) begin errors++; $display("FAIL kill_score got %0d exp 10", bus.score); end
    checks++; if (bus.kill_pulse !== 1'b1) begin errors++; $display("FAIL kill_pulse got %b exp 1", bus.kill_pulse); end
    tick();
    checks++; if (bus.kill_pulse !== 1'b0) begin errors++; $display("FAIL kill_pulse_len got %b exp 0", bus.kill_pulse); end
  endtask

  task automatic test_multi_shot();
    pixels(4'd1, 3'b110, 3);
    frame(1'b0);
    checks++; if (bus.shot_hit !== 3'b110) begin errors++; $display("FAIL multi1_shot_hit got %b exp 110", bus.shot_hit); end
    checks++; if (dut.hp_q[1] !== 3'd1) begin errors++; $display("FAIL multi1_hp1 got %0d exp 1", dut.hp_q[1]); end
    checks++; if (bus.kill_pulse !== 1'b0) begin errors++; $display("FAIL multi1_kill got %b exp 0", bus.kill_pulse); end
    pixels(4'd1, 3'b110, 3);
    frame(1'b0);
    checks++; if (bus.shot_hit !== 3'b110) begin errors++; $display("FAIL multi2_shot_hit got %b exp 110", bus.shot_hit); end
    checks++; if (bus.alive_mask !== 2'b00) begin errors++; $display("FAIL multi2_alive got %b exp 00", bus.alive_mask); end
    checks++; if (bus.score !== 16'd20) begin errors++; $display("FAIL multi2_score got %0d exp 20", bus.score); end
    checks++; if (bus.wave_clear !== 1'b1) begin errors++; $display("FAIL multi2_wave_clear got %b exp 1", bus.wave_clear); end
  endtask

  task automatic test_wave_clear();
    pixels(4'd0, 3'b001, 3);
    repeat (10) frame(1'b1);
    repeat (59) frame(1'b0);
    checks++; if (bus.wave_clear !== 1'b1) begin errors++; $display("FAIL wc59_wave_clear got %b exp 1", bus.wave_clear); end
    checks++; if (bus.wave_count !== 8'd0) begin errors++; $display("FAIL wc59_wave got %0d exp 0", bus.wave_count); end
    checks++; if (bus.alive_mask !== 2'b00) begin errors++; $display("FAIL wc59_alive got %b exp 00", bus.alive_mask); end
    frame(1'b0);
    checks++; if (bus.alive_mask !== 2'b11) begin errors++; $display("FAIL reload_alive got %b exp 11", bus.alive_mask); end
    checks++; if (bus.wave_count !== 8'd1) begin errors++; $display("FAIL reload_wave got %0d exp 1", bus.wave_count); end
    checks++; if (bus.wave_clear !== 1'b0) begin errors++; $display("FAIL reload_wave_clear got %b exp 0", bus.wave_clear); end
    pixels(4'd0, 3'b001, 2);
    frame(1'b0);
    checks++; if (bus.shot_hit !== 3'b001) begin errors++; $display("FAIL reload_hit_shot got %b exp 001", bus.shot_hit); end
    checks++; if (bus.alive_mask !== 2'b11) begin errors++; $display("FAIL reload_hp_alive got %b exp 11", bus.alive_mask); end
  endtask

  task automatic test_pause_run();
    bus.pause = 1'b1;
    pixels(4'd0, 3'b001, 3);
    frame(1'b1);
    checks++; if (bus.shot_hit !== 3'b000) begin errors++; $display("FAIL pause_sof_shot got %b exp 000", bus.shot_hit); end
    frame(1'b0);
    checks++; if (bus.alive_mask !== 2'b11) begin errors++; $display("FAIL pause_alive got %b exp 11", bus.alive_mask); end
    checks++; if (bus.kill_pulse !== 1'b0) begin errors++; $display("FAIL pause_kill got %b exp 0", bus.kill_pulse); end
  endtask

  task automatic test_back_to_back();
    bus.start_of_frame = 1'b1;
    tick();
    bus.start_of_frame = 1'b0;
    pixels(4'd1, 3'b100, 1);
    checks++; if (bus.shot_hit !== 3'b000) begin errors++; $display("FAIL b2b_first_shot got %b exp 000", bus.shot_hit); end
    frame(1'b0);
    checks++; if (bus.shot_hit !== 3'b100) begin errors++; $display("FAIL b2b_carry_shot got %b exp 100", bus.shot_hit); end
    checks++; if (dut.hp_q[1] !== 3'd1) begin errors++; $display("FAIL b2b_hp1 got %0d exp 1", dut.hp_q[1]); end
  endtask

  task automatic test_reset_mid();
    pixels(4'd0, 3'b001, 2);
    bus.start_of_frame = 1'b1;
    tick();
    bus.start_of_frame = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.alive_mask !== 2'b11) begin errors++; $display("FAIL rstc_alive got %b exp 11", bus.alive_mask); end
    checks++; if (bus.score !== 16'd0) begin errors++; $display("FAIL rstc_score got %0d exp 0", bus.score); end
    checks++; if (bus.wave_count !== 8'd0) begin errors++; $display("FAIL rstc_wave got %0d exp 0", bus.wave_count); end
    checks++; if (bus.kill_pulse !== 1'b0) begin errors++; $display("FAIL rstc_kill got %b exp 0", bus.kill_pulse); end
    checks++; if (bus.shot_hit !== 3'b000) begin errors++; $display("FAIL rstc_shot got %b exp 000", bus.shot_hit); end
    pixels(4'd5, 3'b111, 3);
    frame(1'b0);
    checks++; if (bus.shot_hit !== 3'b000) begin errors++; $display("FAIL id5_shot got %b exp 000", bus.shot_hit); end
    checks++; if (dut.hp_q[0] !== 3'd2) begin errors++; $display("FAIL id5_hp0 got %0d exp 2", dut.hp_q[0]); end
    pixels(4'd0, 3'b001, 2);
    pixels(4'd1, 3'b001, 2);
    frame(1'b0);
    checks++; if (bus.shot_hit !== 3'b001) begin errors++; $display("FAIL both1_shot got %b exp 001", bus.shot_hit); end
    checks++; if (bus.alive_mask !== 2'b11) begin errors++; $display("FAIL both1_alive got %b exp 11", bus.alive_mask); end
    pixels(4'd0, 3'b001, 2);
    pixels(4'd1, 3'b001, 2);
    frame(1'b0);
    checks++; if (bus.alive_mask !== 2'b00) begin errors++; $display("FAIL both2_alive got %b exp 00", bus.alive_mask); end
    checks++; if (bus.score !== 16'd20) begin errors++; $display("FAIL both2_score got %0d exp 20", bus.score); end
    checks++; if (bus.kill_pulse !== 1'b1) begin errors++; $display("FAIL both2_kill got %b exp 1", bus.kill_pulse); end
    tick();
    checks++; if (bus.kill_pulse !== 1'b0) begin errors++; $display("FAIL both2_kill_len got %b exp 0", bus.kill_pulse); end
    checks++; if (bus.wave_clear !== 1'b1) begin errors++; $display("FAIL both2_wave_clear got %b exp 1", bus.wave_clear); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.wave_clear !== 1'b0) begin errors++; $display("FAIL rstw_wave_clear got %b exp 0", bus.wave_clear); end
    checks++; if (bus.alive_mask !== 2'b11) begin errors++; $display("FAIL rstw_alive got %b exp 11", bus.alive_mask); end
    checks++; if (bus.score !== 16'd0) begin errors++; $display("FAIL rstw_score got %0d exp 0", bus.score); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_score [5];
    exp_score[0] = 16'd16382;
    exp_score[1] = 16'd32764;
    exp_score[2] = 16'd49146;
    exp_score[3] = 16'hFFF8;
    exp_score[4] = 16'hFFFF;
    for (int w = 0; w < 5; w++) begin
      pixels2(4'd0, 3'b001);
      pixels2(4'd1, 3'b010);
      frame2();
      checks++; if (bus2.score !== exp_score[w]) begin errors++; $display("FAIL sat_score[%0d] got %h exp %h", w, bus2.score, exp_score[w]); end
      checks++; if (bus2.kill_pulse !== 1'b1) begin errors++; $display("FAIL sat_kill[%0d] got %b exp 1", w, bus2.kill_pulse); end
      checks++; if (bus2.shot_hit !== 3'b011) begin errors++; $display("FAIL sat_shot[%0d] got %b exp 011", w, bus2.shot_hit); end
      tick();
      checks++; if (bus2.kill_pulse !== 1'b0) begin errors++; $display("FAIL sat_kill_len[%0d] got %b exp 0", w, bus2.kill_pulse); end
      frame2();
      checks++; if (bus2.wave_count !== 8'(w + 1)) begin errors++; $display("FAIL sat_wave[%0d] got %0d exp %0d", w, bus2.wave_count, w + 1); end
    end
    checks++; if (bus2.alive_mask !== 2'b11) begin errors++; $display("FAIL sat_alive got %b exp 11", bus2.alive_mask); end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_single_hit();
    test_kill();
    test_multi_shot();
    test_wave_clear();
    test_pause_run();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
